toggle_monitor: RTL and testbench



---
 rtl/toggle_monitor_if.sv | 25 ++
 rtl/toggle_monitor.sv | 125 ++++++++++++
 tb/tb_toggle_monitor.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toggle_monitor_if.sv
// Snapshot stream between toggle_monitor (master) and a status/debug collector (slave).
// Signal names follow the monitor's point of view.
interface toggle_monitor_if #(
  parameter int K_NIN   = 1,
  parameter int K_CNT_W = 8
) ();
  localparam int LW = (K_NIN > 1) ? $clog2(K_NIN) : 1;

  logic               o_valid;
  logic               i_ready;
  logic [LW-1:0]      o_lane;
  logic [K_CNT_W-1:0] o_count;
  logic               o_last;
  logic               o_overrun;

  modport master (
    output o_valid, o_lane, o_count, o_last, o_overrun,
    input  i_ready
  );

  modport slave (
    input  o_valid, o_lane, o_count, o_last, o_overrun,
    output i_ready
  );
endinterface

// File: rtl/toggle_monitor.sv
// Counts per-lane edges over fixed windows and streams each window's counts
// one lane per beat; a window that ends mid-send is dropped and flagged.
module toggle_monitor #(
  parameter int K_NIN    = 1,
  parameter int K_CNT_W  = 8,
  parameter int K_WINDOW = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [K_NIN-1:0] i_in,
  toggle_monitor_if.master bus
);
  localparam int LW = (K_NIN > 1) ? $clog2(K_NIN) : 1;
  localparam int WW = $clog2(K_WINDOW);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]         r_state;
  logic [LW-1:0]      r_idx;
  logic [WW-1:0]      r_wcnt;
  logic [K_NIN-1:0]   r_prev;
  logic               r_prev_vld;
  logic               r_overrun;

  logic               w_wend;
  logic               w_hs;
  logic               w_is_last;
  logic               w_capture;
  logic [K_CNT_W-1:0] w_count;
  logic [K_CNT_W-1:0] w_lane_cnt [K_NIN];

  assign w_wend    = (r_wcnt == WW'(K_WINDOW - 1));
  assign w_hs      = (r_state == S_SEND) && bus.i_ready;
  assign w_is_last = (r_idx == LW'(K_NIN - 1));
  // A new snapshot is taken only when nothing is left to send after this cycle.
  assign w_capture = w_wend && ((r_state == S_IDLE) || (w_hs && w_is_last));

  genvar gi;
  generate
    for (gi = 0; gi < K_NIN; gi++) begin : g_lane
      logic [K_CNT_W-1:0] r_cnt;
      logic [K_CNT_W-1:0] r_snap;
      logic [K_CNT_W-1:0] w_cnt_next;

      assign w_cnt_next = (r_prev_vld && (i_in[gi] != r_prev[gi]) && (r_cnt != {K_CNT_W{1'b1}}))
                          ? r_cnt + 1'b1 : r_cnt;
      assign w_lane_cnt[gi] = r_snap;

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_cnt <= '0;
        end else if (w_wend) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= w_cnt_next;
        end
      end

      // The edge seen in the window-end cycle itself belongs to the closing window.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_snap <= '0;
        end else if (w_capture) begin
          r_snap <= w_cnt_next;
        end
      end
    end
  endgenerate

  always_comb begin
    w_count = '0;
    for (int k = 0; k < K_NIN; k++) begin
      if (r_idx == LW'(k)) begin
        w_count = w_lane_cnt[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_wcnt     <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_prev     <= i_in;
      r_prev_vld <= 1'b1;
      r_wcnt     <= w_wend ? '0 : r_wcnt + 1'b1;
      r_overrun  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_wend) begin
            r_idx   <= '0;
            r_state <= S_SEND;
          end
        end
        default: begin
          if (w_hs && w_is_last) begin
            if (w_wend) begin
              r_idx <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            if (w_hs) begin
              r_idx <= r_idx + 1'b1;
            end
            if (w_wend) begin
              r_overrun <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.o_valid   = (r_state == S_SEND);
  assign bus.o_lane    = r_idx;
  assign bus.o_count   = w_count;
  assign bus.o_last    = (r_state == S_SEND) && w_is_last;
  assign bus.o_overrun = r_overrun;
endmodule

// File: tb/tb_toggle_monitor.sv
// Two monitors share stimulus: A (2 lanes, 4-bit, window 8) and B (2 lanes, 3-bit, window 16).
// A window-level model predicts the stream; scenario tasks also pin hand-derived values.
module tb_toggle_monitor;
  localparam int NIN = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NIN-1:0] in_vec;
  logic           ready;

  toggle_monitor_if #(.K_NIN(NIN), .K_CNT_W(4)) bus_a ();
  toggle_monitor_if #(.K_NIN(NIN), .K_CNT_W(3)) bus_b ();
  assign bus_a.i_ready = ready;
  assign bus_b.i_ready = ready;

  toggle_monitor #(.K_NIN(NIN), .K_CNT_W(4), .K_WINDOW(8)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(in_vec), .bus(bus_a)
  );
  toggle_monitor #(.K_NIN(NIN), .K_CNT_W(3), .K_WINDOW(16)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(in_vec), .bus(bus_b)
  );

  always #5 clk = ~clk;

  logic [1:0] obs_valid, obs_last, obs_ovr;
  logic [0:0] obs_lane [2];
  logic [3:0] obs_count [2];
  assign obs_valid = {bus_b.o_valid, bus_a.o_valid};
  assign obs_last  = {bus_b.o_last, bus_a.o_last};
  assign obs_ovr   = {bus_b.o_overrun, bus_a.o_overrun};
  always_comb begin
    obs_lane[0]  = bus_a.o_lane;
    obs_lane[1]  = bus_b.o_lane;
    obs_count[0] = bus_a.o_count;
    obs_count[1] = {1'b0, bus_b.o_count};
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Model: per-window edge tallies, the snapshot being sent and how many beats remain.
  int   w_len [2] = '{8, 16};
  int   c_max [2] = '{15, 7};
  int   m_cnt [2][NIN];
  int   m_snap [2][NIN];
  int   m_pend [2];
  int   m_wcnt [2];
  bit   m_ovr [2];
  bit   m_first = 1'b1;
  logic [NIN-1:0] m_prev = '0;

  task automatic tick();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_pend[i] = 0;
        m_wcnt[i] = 0;
        m_ovr[i]  = 1'b0;
        for (int k = 0; k < NIN; k++) begin
          m_cnt[i][k]  = 0;
          m_snap[i][k] = 0;
        end
      end else begin
        if (m_pend[i] > 0 && ready) begin
          $display("beat inst=%0d lane=%0d count=%0d last=%0b", i, obs_lane[i], obs_count[i], obs_last[i]);
          m_pend[i]--;
        end
        if (!m_first) begin
          for (int k = 0; k < NIN; k++) begin
            if (in_vec[k] != m_prev[k] && m_cnt[i][k] < c_max[i]) m_cnt[i][k]++;
          end
        end
        m_ovr[i] = 1'b0;
        if (m_wcnt[i] == w_len[i] - 1) begin
          if (m_pend[i] == 0) begin
            for (int k = 0; k < NIN; k++) m_snap[i][k] = m_cnt[i][k];
            m_pend[i] = NIN;
          end else begin
            m_ovr[i] = 1'b1;
          end
          for (int k = 0; k < NIN; k++) m_cnt[i][k] = 0;
        end
        m_wcnt[i] = (m_wcnt[i] + 1) % w_len[i];
      end
    end
    m_first = !rst_n;
    m_prev  = in_vec;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_vec = '0; ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs_valid[i] !== 1'b0 || obs_lane[i] !== 1'b0 || obs_count[i] !== 4'd0 ||
          obs_last[i] !== 1'b0 || obs_ovr[i] !== 1'b0)
        $display("FAIL reset inst=%0d: valid=%b lane=%b count=%0d last=%b ovr=%b, want all 0",
                 i, obs_valid[i], obs_lane[i], obs_count[i], obs_last[i], obs_ovr[i]);
      else n_pass++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_vec = NIN'(c & 1);
      if (c == 7) begin
        n_checks++;
        if (bus_a.o_valid !== 1'b0) $display("FAIL basic_early_valid: valid=%b, want 0", bus_a.o_valid);
        else n_pass++;
      end
      if (c == 8 || c == 16) begin
        n_checks++;
        if (bus_a.o_valid !== 1'b1 || bus_a.o_lane !== 1'b0 || bus_a.o_last !== 1'b0 ||
            bus_a.o_count !== ((c == 8) ? 4'd7 : 4'd8))
          $display("FAIL basic_lane0 c=%0d: valid=%b lane=%0d count=%0d last=%b, want 1/0/%0d/0",
                   c, bus_a.o_valid, bus_a.o_lane, bus_a.o_count, bus_a.o_last, (c == 8) ? 7 : 8);
        else n_pass++;
      end
      if (c == 9 || c == 17) begin
        n_checks++;
        if (bus_a.o_valid !== 1'b1 || bus_a.o_lane !== 1'b1 || bus_a.o_count !== 4'd0 || bus_a.o_last !== 1'b1)
          $display("FAIL basic_lane1 c=%0d: valid=%b lane=%0d count=%0d last=%b, want 1/1/0/1",
                   c, bus_a.o_valid, bus_a.o_lane, bus_a.o_count, bus_a.o_last);
        else n_pass++;
      end
      n_checks++;
      if (bus_a.o_overrun !== 1'b0) $display("FAIL basic_overrun c=%0d: ovr=%b, want 0", c, bus_a.o_overrun);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ready = 1'b1;
    for (int c = 0; c < 19; c++) begin
      in_vec = NIN'(c & 1);
      if (c == 16) begin
        n_checks++;
        if (bus_b.o_valid !== 1'b1 || bus_b.o_lane !== 1'b0 || bus_b.o_count !== 3'd7)
          $display("FAIL sat_lane0: valid=%b lane=%0d count=%0d, want 1/0/7", bus_b.o_valid, bus_b.o_lane, bus_b.o_count);
        else n_pass++;
      end
      if (c == 17) begin
        n_checks++;
        if (bus_b.o_lane !== 1'b1 || bus_b.o_count !== 3'd0 || bus_b.o_last !== 1'b1)
          $display("FAIL sat_lane1: lane=%0d count=%0d last=%b, want 1/0/1", bus_b.o_lane, bus_b.o_count, bus_b.o_last);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      in_vec = NIN'(c & 1);
      ready  = (c < 8 || c >= 11);
      if (c >= 8 && c <= 11) begin
        n_checks++;
        if (bus_a.o_valid !== 1'b1 || bus_a.o_lane !== 1'b0 || bus_a.o_count !== 4'd7)
          $display("FAIL bp_hold c=%0d: valid=%b lane=%0d count=%0d, want 1/0/7", c, bus_a.o_valid, bus_a.o_lane, bus_a.o_count);
        else n_pass++;
      end
      if (c == 12) begin
        n_checks++;
        if (bus_a.o_valid !== 1'b1 || bus_a.o_lane !== 1'b1 || bus_a.o_last !== 1'b1)
          $display("FAIL bp_next: valid=%b lane=%0d last=%b, want 1/1/1", bus_a.o_valid, bus_a.o_lane, bus_a.o_last);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_overrun();
    int n_ovr = 0;
    do_reset();
    for (int c = 0; c < 26; c++) begin
      in_vec = NIN'(c & 1);
      ready  = (c >= 20);
      if (c >= 8 && c <= 22 && bus_a.o_overrun === 1'b1) n_ovr++;
      if (c == 16) begin
        n_checks++;
        if (bus_a.o_overrun !== 1'b1) $display("FAIL ovr_pulse: ovr=%b, want 1", bus_a.o_overrun);
        else n_pass++;
      end
      if (c == 20 || c == 21) begin
        n_checks++;
        if (bus_a.o_valid !== 1'b1 || bus_a.o_lane !== 1'(c - 20) || bus_a.o_count !== ((c == 20) ? 4'd7 : 4'd0))
          $display("FAIL ovr_old_snapshot c=%0d: valid=%b lane=%0d count=%0d, want 1/%0d/%0d",
                   c, bus_a.o_valid, bus_a.o_lane, bus_a.o_count, c - 20, (c == 20) ? 7 : 0);
        else n_pass++;
      end
      if (c == 24) begin
        n_checks++;
        if (bus_a.o_valid !== 1'b1 || bus_a.o_lane !== 1'b0 || bus_a.o_count !== 4'd8)
          $display("FAIL ovr_recover: valid=%b lane=%0d count=%0d, want 1/0/8", bus_a.o_valid, bus_a.o_lane, bus_a.o_count);
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (n_ovr != 1) $display("FAIL ovr_width: pulses=%0d cycles, want 1", n_ovr);
    else n_pass++;
  endtask

  task automatic test_coincidence();
    do_reset();
    for (int c = 0; c < 18; c++) begin
      in_vec = NIN'(c & 1);
      ready  = (c >= 14);
      if (c == 15) begin
        n_checks++;
        if (bus_a.o_valid !== 1'b1 || bus_a.o_lane !== 1'b1)
          $display("FAIL coin_last_beat: valid=%b lane=%0d, want 1/1", bus_a.o_valid, bus_a.o_lane);
        else n_pass++;
      end
      if (c == 16) begin
        n_checks++;
        if (bus_a.o_valid !== 1'b1 || bus_a.o_lane !== 1'b0 || bus_a.o_count !== 4'd8 || bus_a.o_overrun !== 1'b0)
          $display("FAIL coin_new_window: valid=%b lane=%0d count=%0d ovr=%b, want 1/0/8/0",
                   bus_a.o_valid, bus_a.o_lane, bus_a.o_count, bus_a.o_overrun);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_reset_midsend();
    int t = 0;
    do_reset();
    ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_vec = NIN'(t & 1); t++;
      if (c == 9) begin
        n_checks++;
        if (bus_a.o_valid !== 1'b1 || bus_a.o_lane !== 1'b1)
          $display("FAIL rstmid_pending: valid=%b lane=%0d, want 1/1", bus_a.o_valid, bus_a.o_lane);
        else n_pass++;
        rst_n = 1'b0;
        ready = 1'b0;
      end
      tick();
    end
    rst_n = 1'b1;
    ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_vec = NIN'(t & 1); t++;
      if (c == 0) begin
        n_checks++;
        if (bus_a.o_valid !== 1'b0 || bus_a.o_lane !== 1'b0 || bus_a.o_count !== 4'd0 ||
            bus_a.o_last !== 1'b0 || bus_a.o_overrun !== 1'b0)
          $display("FAIL rstmid_clear: valid=%b lane=%0d count=%0d last=%b ovr=%b, want all 0",
                   bus_a.o_valid, bus_a.o_lane, bus_a.o_count, bus_a.o_last, bus_a.o_overrun);
        else n_pass++;
      end
      if (c == 8) begin
        n_checks++;
        if (bus_a.o_valid !== 1'b1 || bus_a.o_lane !== 1'b0 || bus_a.o_count !== 4'd7)
          $display("FAIL rstmid_first_window: valid=%b lane=%0d count=%0d, want 1/0/7",
                   bus_a.o_valid, bus_a.o_lane, bus_a.o_count);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_random();
    int thr = 10;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 20 == 0) thr = $urandom_range(0, 10);
      in_vec = NIN'($urandom);
      ready  = ($urandom_range(0, 9) < thr);
      rst_n  = ($urandom_range(0, 249) != 0);
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs_valid[i] !== (m_pend[i] > 0))
          $display("FAIL rand_valid inst=%0d c=%0d: got %b, want %0d", i, c, obs_valid[i], m_pend[i] > 0);
        else n_pass++;
        n_checks++;
        if (obs_ovr[i] !== m_ovr[i])
          $display("FAIL rand_overrun inst=%0d c=%0d: got %b, want %b", i, c, obs_ovr[i], m_ovr[i]);
        else n_pass++;
        if (m_pend[i] > 0) begin
          n_checks++;
          if (obs_lane[i] !== 1'(NIN - m_pend[i]) || obs_count[i] !== 4'(m_snap[i][NIN - m_pend[i]]) ||
              obs_last[i] !== (m_pend[i] == 1))
            $display("FAIL rand_beat inst=%0d c=%0d: lane=%0d count=%0d last=%b, want %0d/%0d/%0d",
                     i, c, obs_lane[i], obs_count[i], obs_last[i], NIN - m_pend[i],
                     m_snap[i][NIN - m_pend[i]], m_pend[i] == 1);
          else n_pass++;
        end else begin
          n_checks++;
          if (obs_last[i] !== 1'b0) $display("FAIL rand_idle_last inst=%0d c=%0d: got %b, want 0", i, c, obs_last[i]);
          else n_pass++;
        end
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_vec = '0; ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_overrun();
    test_coincidence();
    test_reset_midsend();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
